// File: rtl/pciecfg_arb.sv
// pciecfg_arb
//   Round-robin arbiter/sequencer sharing the PCIe core's single
//   cfg_mgmt port between NUM_REQ requesters. One access at a time:
//   the enable is held until the core reports done (or TIMEOUT cycles
//   elapse), then a one-cycle response pulse goes back to the owner.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake
//   req_wr/dwaddr/byte_en/data  flattened per-requester request fields
//   resp_valid             one-cycle completion pulse to the owner
//   resp_data/resp_timeout shared completion bus, held until next response
//   busy                   high whenever not idle
//   cfg_mgmt_*             PCIe hard-block configuration port
module pciecfg_arb #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ-1:0]      req_wr,
   input  logic [NUM_REQ*10-1:0]   req_dwaddr,
   input  logic [NUM_REQ*4-1:0]    req_byte_en,
   input  logic [NUM_REQ*32-1:0]   req_data,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [31:0]             resp_data,
   output logic                    resp_timeout,
   output logic                    busy,
   output logic [9:0]              cfg_mgmt_dwaddr,
   output logic                    cfg_mgmt_rd_en,
   output logic                    cfg_mgmt_wr_en,
   output logic [3:0]              cfg_mgmt_byte_en,
   output logic [31:0]             cfg_mgmt_di,
   input  logic [31:0]             cfg_mgmt_do,
   input  logic                    cfg_mgmt_rd_wr_done
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] owner;
   logic          cur_wr;
   logic [CW-1:0] tmo_cnt;

   logic [IW-1:0] grant_idx;
   logic          grant_any;
   int            cand;

   logic [9:0]    dwaddr_arr [NUM_REQ];
   logic [3:0]    byte_en_arr [NUM_REQ];
   logic [31:0]   data_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign dwaddr_arr[gi]  = req_dwaddr[gi*10 +: 10];
         assign byte_en_arr[gi] = req_byte_en[gi*4 +: 4];
         assign data_arr[gi]    = req_data[gi*32 +: 32];
      end
   endgenerate

   // Scan from the farthest candidate back to rr_ptr so the last hit,
   // which is the one closest to rr_ptr, wins.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         cand = (int'(rr_ptr) + k) % NUM_REQ;
         if (req_valid[cand]) begin
            grant_idx = IW'(cand);
            grant_any = 1'b1;
         end
      end
   end

   // Ready is gated by rst so nothing can be accepted while reset is held.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && grant_any && !rst)
         req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         owner            <= '0;
         cur_wr           <= 1'b0;
         tmo_cnt          <= '0;
         resp_valid       <= '0;
         resp_data        <= '0;
         resp_timeout     <= 1'b0;
         busy             <= 1'b0;
         cfg_mgmt_dwaddr  <= '0;
         cfg_mgmt_rd_en   <= 1'b0;
         cfg_mgmt_wr_en   <= 1'b0;
         cfg_mgmt_byte_en <= '0;
         cfg_mgmt_di      <= '0;
      end else begin
         resp_valid <= '0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner            <= grant_idx;
                  cur_wr           <= req_wr[grant_idx];
                  cfg_mgmt_dwaddr  <= dwaddr_arr[grant_idx];
                  cfg_mgmt_di      <= data_arr[grant_idx];
                  cfg_mgmt_byte_en <= req_wr[grant_idx] ? byte_en_arr[grant_idx] : 4'h0;
                  cfg_mgmt_rd_en   <= !req_wr[grant_idx];
                  cfg_mgmt_wr_en   <= req_wr[grant_idx];
                  tmo_cnt          <= '0;
                  busy             <= 1'b1;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               // Done wins over a simultaneous timeout on the last cycle.
               if (cfg_mgmt_rd_wr_done) begin
                  cfg_mgmt_rd_en    <= 1'b0;
                  cfg_mgmt_wr_en    <= 1'b0;
                  resp_data         <= cur_wr ? 32'h0 : cfg_mgmt_do;
                  resp_timeout      <= 1'b0;
                  resp_valid[owner] <= 1'b1;
                  state             <= RESP;
               end else if (tmo_cnt == CW'(TIMEOUT-1)) begin
                  cfg_mgmt_rd_en    <= 1'b0;
                  cfg_mgmt_wr_en    <= 1'b0;
                  resp_data         <= 32'hFFFF_FFFF;
                  resp_timeout      <= 1'b1;
                  resp_valid[owner] <= 1'b1;
                  state             <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            RESP: begin
               rr_ptr <= (owner == IW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               cfg_mgmt_rd_en <= 1'b0;
               cfg_mgmt_wr_en <= 1'b0;
               busy           <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pciecfg_arb.sv
// tb_pciecfg_arb
//   Randomized bench for pciecfg_arb with a transaction-level model:
//   round-robin winner prediction, a core responder with planned
//   latencies (including timeouts) and a response scoreboard.
module tb_pciecfg_arb;

   localparam int N   = 3;
   localparam int TMO = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      req_wr = '0;
   logic [N*10-1:0]   req_dwaddr = '0;
   logic [N*4-1:0]    req_byte_en = '0;
   logic [N*32-1:0]   req_data = '0;
   logic [N-1:0]      resp_valid;
   logic [31:0]       resp_data;
   logic              resp_timeout;
   logic              busy;
   logic [9:0]        cfg_mgmt_dwaddr;
   logic              cfg_mgmt_rd_en;
   logic              cfg_mgmt_wr_en;
   logic [3:0]        cfg_mgmt_byte_en;
   logic [31:0]       cfg_mgmt_di;
   logic [31:0]       core_do = '0;
   logic              core_done = 1'b0;

   pciecfg_arb #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_dwaddr(req_dwaddr), .req_byte_en(req_byte_en), .req_data(req_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout),
      .busy(busy),
      .cfg_mgmt_dwaddr(cfg_mgmt_dwaddr), .cfg_mgmt_rd_en(cfg_mgmt_rd_en),
      .cfg_mgmt_wr_en(cfg_mgmt_wr_en), .cfg_mgmt_byte_en(cfg_mgmt_byte_en),
      .cfg_mgmt_di(cfg_mgmt_di), .cfg_mgmt_do(core_do),
      .cfg_mgmt_rd_wr_done(core_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      bit         wr;
      logic [9:0] addr;
      logic [3:0] be;
      logic [31:0] data;
      int         lat;     // 0 = core never answers
      logic [31:0] dout;
   } xact_t;

   typedef struct {
      int          idx;
      logic [31:0] data;
      bit          tmo;
   } rsp_t;

   xact_t cfg_q[$];
   rsp_t  rsp_q[$];

   int    checks = 0;
   int    failures = 0;
   bit    in_flight = 1'b0;
   int    model_ptr = 0;
   bit    accepted [N];
   bit    issue_en = 1'b0;
   bit    rst_sampled = 1'b1;
   xact_t cur;
   bit    cur_act = 1'b0;
   int    cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      rst_sampled = rst;
   end

   // Arbitration checker and expectation producer.
   initial forever begin
      logic [N-1:0] exp_ready;
      bit found;
      @(negedge clk);
      if (rst_sampled) begin
         chk("rst_ctrl", 32'({resp_valid, resp_timeout, busy, cfg_mgmt_rd_en,
                              cfg_mgmt_wr_en, cfg_mgmt_byte_en}), 32'h0);
         chk("rst_dwaddr", 32'(cfg_mgmt_dwaddr), 32'h0);
         chk("rst_di", cfg_mgmt_di, 32'h0);
         chk("rst_resp_data", resp_data, 32'h0);
      end else begin
         chk("busy", 32'(busy), 32'(in_flight));
      end
      exp_ready = '0;
      found = 1'b0;
      if (!rst && !in_flight) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (model_ptr + k) % N;
            if (!found && req_valid[c]) begin
               exp_ready[c] = 1'b1;
               found = 1'b1;
            end
         end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            if (req_valid[k] && req_ready[k]) begin
               xact_t x;
               rsp_t  r;
               int    sel;
               accepted[k] = 1'b1;
               x.idx  = k;
               x.wr   = req_wr[k];
               x.addr = req_dwaddr[k*10 +: 10];
               x.be   = req_wr[k] ? req_byte_en[k*4 +: 4] : 4'h0;
               x.data = req_data[k*32 +: 32];
               sel    = int'($urandom_range(0, 99));
               x.lat  = (sel < 70) ? int'($urandom_range(1, 6)) : (sel < 85) ? TMO : 0;
               x.dout = $urandom;
               r.idx  = k;
               r.tmo  = (x.lat == 0);
               r.data = (x.lat == 0) ? 32'hFFFF_FFFF : (x.wr ? 32'h0 : x.dout);
               cfg_q.push_back(x);
               rsp_q.push_back(r);
               model_ptr = (k + 1) % N;
               in_flight = 1'b1;
            end
         end
      end
      if (resp_valid != '0) in_flight = 1'b0;
   end

   // Response monitor.
   initial forever begin
      @(negedge clk);
      if (resp_valid != '0) begin
         if (rsp_q.size() == 0) begin
            chk("resp_unexpected", 32'(resp_valid), 32'h0);
         end else begin
            rsp_t r;
            logic [N-1:0] oh;
            r = rsp_q.pop_front();
            oh = '0;
            oh[r.idx] = 1'b1;
            $display("resp req=%0d data=%h timeout=%0d", r.idx, resp_data, resp_timeout);
            chk("resp_valid", 32'(resp_valid), 32'(oh));
            chk("resp_data", resp_data, r.data);
            chk("resp_timeout", 32'(resp_timeout), 32'(r.tmo));
         end
      end
   end

   // One clock of stimulus: model reset, core responder, requesters.
   task automatic step();
      logic en;
      @(posedge clk);
      #1;
      if (rst_sampled) begin
         in_flight = 1'b0;
         model_ptr = 0;
         cfg_q.delete();
         rsp_q.delete();
         cur_act = 1'b0;
         cnt = 0;
      end
      en = cfg_mgmt_rd_en | cfg_mgmt_wr_en;
      if (en) begin
         if (!cur_act) begin
            cur_act = 1'b1;
            cnt = 0;
            if (cfg_q.size() != 0) begin
               cur = cfg_q.pop_front();
               chk("en_kind", 32'({cfg_mgmt_rd_en, cfg_mgmt_wr_en}), cur.wr ? 32'h1 : 32'h2);
               chk("cfg_dwaddr", 32'(cfg_mgmt_dwaddr), 32'(cur.addr));
               chk("cfg_byte_en", 32'(cfg_mgmt_byte_en), 32'(cur.be));
               chk("cfg_di", cfg_mgmt_di, cur.data);
            end else begin
               chk("en_unexpected", 32'(cfg_q.size()), 32'h1);
               cur.lat = 1;
               cur.wr  = cfg_mgmt_wr_en;
               cur.dout = '0;
            end
         end
         cnt++;
         core_done = (cur.lat != 0) && (cnt == cur.lat);
         core_do   = core_done ? cur.dout : $urandom;
      end else begin
         if (cur_act) begin
            $display("cfg req=%0d wr=%0d addr=%h en_cycles=%0d", cur.idx, cur.wr, cur.addr, cnt);
            chk("en_cycles", 32'(cnt), 32'((cur.lat == 0) ? TMO : cur.lat));
            cur_act = 1'b0;
         end
         core_done = ($urandom_range(0, 7) == 0);   // stale pulses must be ignored
         core_do   = $urandom;
      end
      for (int i = 0; i < N; i++) begin
         if (accepted[i]) begin
            accepted[i] = 1'b0;
            req_valid[i] = 1'b0;
            if (issue_en && $urandom_range(0, 1) == 0) begin
               req_valid[i]              = 1'b1;
               req_wr[i]                 = 1'($urandom_range(0, 1));
               req_dwaddr[i*10 +: 10]    = 10'($urandom);
               req_byte_en[i*4 +: 4]     = 4'($urandom);
               req_data[i*32 +: 32]      = $urandom;
            end
         end else if (req_valid[i]) begin
            if (issue_en && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
         end else if (issue_en && $urandom_range(0, 3) == 0) begin
            req_valid[i]              = 1'b1;
            req_wr[i]                 = 1'($urandom_range(0, 1));
            req_dwaddr[i*10 +: 10]    = 10'($urandom);
            req_byte_en[i*4 +: 4]     = 4'($urandom);
            req_data[i*32 +: 32]      = $urandom;
         end
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((in_flight || req_valid != '0) && k < 800) begin
         step();
         k++;
      end
      repeat (3) step();
      chk("drain", 32'({in_flight, req_valid}), 32'h0);
   endtask

   initial begin
      int k;
      for (int i = 0; i < N; i++) accepted[i] = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;

      issue_en = 1'b1;
      repeat (3000) step();
      issue_en = 1'b0;
      drain();

      // Directed write from requester 1, then reset while wr_en is high.
      req_valid[1]         = 1'b1;
      req_wr[1]            = 1'b1;
      req_dwaddr[10 +: 10] = 10'h001;
      req_byte_en[4 +: 4]  = 4'b0011;
      req_data[32 +: 32]   = 32'h0000_0406;
      k = 0;
      while (!cfg_mgmt_wr_en && k < 20) begin
         step();
         k++;
      end
      chk("mid_wr_en", 32'(cfg_mgmt_wr_en), 32'h1);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // rr_ptr must be back at 0: requester 1 should beat requester 2.
      for (int i = 1; i < N; i++) begin
         req_valid[i]           = 1'b1;
         req_wr[i]              = 1'b0;
         req_dwaddr[i*10 +: 10] = 10'($urandom);
         req_data[i*32 +: 32]   = $urandom;
      end
      issue_en = 1'b1;
      repeat (600) step();
      issue_en = 1'b0;
      drain();
      chk("cfg_q_empty", 32'(cfg_q.size()), 32'h0);
      chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
